// File: rtl/ttl_374_bank_sync.sv
// Bank of CHANNELS independent WIDTH-bit 74LS374/373-style register chains of DEPTH stages,
// clocked by a strobe sampled on Clk; Q is combinational from OCn, strobe marks each chain shift.
module ttl_374_bank_sync #(
  parameter int              WIDTH     = 8,
  parameter int              CHANNELS  = 1,
  parameter int              DEPTH     = 1,
  parameter int              MODE      = 0,
  parameter int              EDGE      = 0,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter logic [WIDTH-1:0] OFF_VAL   = '1
) (
  input  logic                      Clk,
  input  logic                      RESET,
  input  logic [CHANNELS-1:0]       Cen,
  input  logic [CHANNELS-1:0]       OCn,
  input  logic [CHANNELS*WIDTH-1:0] D,
  output logic [CHANNELS*WIDTH-1:0] Q,
  output logic [CHANNELS-1:0]       strobe
);

  localparam logic EDGE_L = (EDGE != 0);

  if (DEPTH < 1) begin : g_bad_depth
    $error("ttl_374_bank_sync: DEPTH must be >= 1");
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [WIDTH-1:0] stg [DEPTH];
    logic             last_act;
    logic             act;
    logic             open_e;
    logic             close_e;
    logic             strb;

    assign act     = Cen[c] ^ EDGE_L;
    assign open_e  = act & ~last_act;
    assign close_e = ~act & last_act;

    // last_act resets to the active level so a strobe held active through release is not an edge
    always_ff @(posedge Clk or posedge RESET) begin
      if (RESET) begin
        last_act <= 1'b1;
        strb     <= 1'b0;
      end else begin
        last_act <= act;
        strb     <= (MODE == 0) ? open_e : close_e;
      end
    end

    if (MODE == 0) begin : g_374
      always_ff @(posedge Clk or posedge RESET) begin
        if (RESET) begin
          for (int k = 0; k < DEPTH; k++) stg[k] <= RESET_VAL;
        end else if (open_e) begin
          stg[0] <= D[c*WIDTH +: WIDTH];
          for (int k = 1; k < DEPTH; k++) stg[k] <= stg[k-1];
        end
      end
    end else begin : g_373
      // Stage 0 is the transparent latch; downstream stages advance only when it closes
      always_ff @(posedge Clk or posedge RESET) begin
        if (RESET) begin
          for (int k = 0; k < DEPTH; k++) stg[k] <= RESET_VAL;
        end else begin
          if (act) stg[0] <= D[c*WIDTH +: WIDTH];
          if (close_e) begin
            for (int k = 1; k < DEPTH; k++) stg[k] <= stg[k-1];
          end
        end
      end
    end

    assign strobe[c]             = strb;
    assign Q[c*WIDTH +: WIDTH]   = OCn[c] ? OFF_VAL : stg[DEPTH-1];
  end

endmodule

// File: tb/tb_ttl_374_bank_sync.sv
// Directed bench: four configurations of ttl_374_bank_sync sharing one clock and reset.
module tb_ttl_374_bank_sync;

  logic Clk = 1'b0;
  logic RESET;
  always #5 Clk = ~Clk;

  int total = 0;
  int bad   = 0;

  // u0: MODE0 DEPTH1
  logic       c0, o0, s0;
  logic [7:0] d0, q0;
  // u1: MODE0 DEPTH3
  logic       c1, o1, s1;
  logic [7:0] d1, q1;
  // u2: MODE1 DEPTH2
  logic       c2, o2, s2;
  logic [7:0] d2, q2;
  // u3: CHANNELS2 EDGE1
  logic [1:0]  c3, o3, s3;
  logic [15:0] d3, q3;

  ttl_374_bank_sync #(.WIDTH(8), .CHANNELS(1), .DEPTH(1), .MODE(0), .EDGE(0)) u0 (
    .Clk(Clk), .RESET(RESET), .Cen(c0), .OCn(o0), .D(d0), .Q(q0), .strobe(s0));
  ttl_374_bank_sync #(.WIDTH(8), .CHANNELS(1), .DEPTH(3), .MODE(0), .EDGE(0)) u1 (
    .Clk(Clk), .RESET(RESET), .Cen(c1), .OCn(o1), .D(d1), .Q(q1), .strobe(s1));
  ttl_374_bank_sync #(.WIDTH(8), .CHANNELS(1), .DEPTH(2), .MODE(1), .EDGE(0)) u2 (
    .Clk(Clk), .RESET(RESET), .Cen(c2), .OCn(o2), .D(d2), .Q(q2), .strobe(s2));
  ttl_374_bank_sync #(.WIDTH(8), .CHANNELS(2), .DEPTH(1), .MODE(0), .EDGE(1)) u3 (
    .Clk(Clk), .RESET(RESET), .Cen(c3), .OCn(o3), .D(d3), .Q(q3), .strobe(s3));

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic pulse1(input logic [7:0] v);
    d1 = v; c1 = 1'b1;
    tick();
    c1 = 1'b0;
    tick();
  endtask

  initial begin
    int nstb;
    RESET = 1'b1;
    c0 = 1'b1; d0 = 8'h5A; o0 = 1'b0;
    c1 = 1'b0; d1 = 8'h00; o1 = 1'b0;
    c2 = 1'b0; d2 = 8'h00; o2 = 1'b0;
    c3 = 2'b11; d3 = 16'h0000; o3 = 2'b00;
    tick(); tick();
    chk("rst_q0", {8'h0, q0}, 16'h0000);
    chk("rst_s0", {15'h0, s0}, 16'h0000);
    chk("rst_q3", q3, 16'h0000);
    RESET = 1'b0;

    // T1: Cen already high at release is not an edge
    tick();
    chk("t1_noedge_q", {8'h0, q0}, 16'h0000);
    chk("t1_noedge_s", {15'h0, s0}, 16'h0000);
    tick();
    c0 = 1'b0; tick();
    c0 = 1'b1; tick();
    chk("t1_cap_q", {8'h0, q0}, 16'h005A);
    chk("t1_cap_s", {15'h0, s0}, 16'h0001);
    tick();
    chk("t1_s_drop", {15'h0, s0}, 16'h0000);
    chk("t1_hold_q", {8'h0, q0}, 16'h005A);

    // T2: output disable and capture while disabled
    o0 = 1'b1; #1;
    chk("t2_off", {8'h0, q0}, 16'h00FF);
    d0 = 8'h33; c0 = 1'b0; tick();
    c0 = 1'b1; tick();
    chk("t2_off_cap", {8'h0, q0}, 16'h00FF);
    o0 = 1'b0; #1;
    chk("t2_on", {8'h0, q0}, 16'h0033);

    // T4: transparent latch, DEPTH2
    c2 = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      d2 = 8'(i);
      tick();
      chk("t4_ramp_q", {8'h0, q2}, 16'h0000);
      chk("t4_ramp_s", {15'h0, s2}, 16'h0000);
    end
    c2 = 1'b0; d2 = 8'h0F; tick();
    chk("t4_close_q", {8'h0, q2}, 16'h0005);
    chk("t4_close_s", {15'h0, s2}, 16'h0001);
    tick();
    chk("t4_after_q", {8'h0, q2}, 16'h0005);
    chk("t4_after_s", {15'h0, s2}, 16'h0000);

    // T5: falling-edge, two channels
    d3 = 16'hC33C; c3 = 2'b10; tick();
    chk("t5_ch0_q", q3, 16'h003C);
    chk("t5_ch0_s", {14'h0, s3}, 16'h0001);
    c3 = 2'b11; tick();
    d3 = 16'h7EE7; c3 = 2'b00; tick();
    chk("t5_both_q", q3, 16'h7EE7);
    chk("t5_both_s", {14'h0, s3}, 16'h0003);

    // T3: DEPTH3 chain
    pulse1(8'h11); chk("t3_e1", {8'h0, q1}, 16'h0000);
    pulse1(8'h22); chk("t3_e2", {8'h0, q1}, 16'h0000);
    pulse1(8'h33); chk("t3_e3", {8'h0, q1}, 16'h0011);
    d1 = 8'h44; c1 = 1'b1; tick();
    chk("t3_e4_q", {8'h0, q1}, 16'h0022);
    chk("t3_e4_s", {15'h0, s1}, 16'h0001);

    // T6: reset between edges, Cen held active through release
    #2 RESET = 1'b1; #1;
    chk("t6_rst_q", {8'h0, q1}, 16'h0000);
    chk("t6_rst_s", {15'h0, s1}, 16'h0000);
    tick();
    RESET = 1'b0; d1 = 8'h99;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t6_held_s", {15'h0, s1}, 16'h0000);
    end
    c1 = 1'b0; tick();
    c1 = 1'b1; d1 = 8'h77; tick();
    chk("t6_edge_s", {15'h0, s1}, 16'h0001);

    // Cen held high for 5 Clk in total: only the one shift above
    d1 = 8'h88; nstb = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (s1) nstb++;
    end
    chk("t3_hold_strobes", 16'(nstb), 16'h0000);
    c1 = 1'b0; tick();
    pulse1(8'hAA);
    pulse1(8'hBB);
    chk("t3_hold_q", {8'h0, q1}, 16'h0077);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
